uart_tx_fsm: RTL and testbench

- Frame controller for the UART transmitter. It sits directly upstream of and around the 8-bit serializer.
- Accepts a byte handshake and sequences start, data, optional parity and stop bits. It drives the serializer enable, consumes the serializer's done/data outputs, and muxes the TX line.
- One bit is transmitted per clk cycle; clk is already the bit-rate clock.

---
 rtl/uart_tx_fsm.sv | 127 ++++++++++++
 tb/tb_uart_tx_fsm.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fsm.sv
// UART transmit frame controller: sequences start, data, optional parity and stop bits
// around an external serializer. Define UART_TX_STOP2_EN for a second stop bit.
module uart_tx_fsm #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  data_valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  ser_done,
  input  logic                  ser_data,
  output logic                  ser_en,
  output logic                  busy,
  output logic                  TX_OUT,
  output logic                  tx_done,
  output logic                  sync_err
);

  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BW-1:0] BCNT_LAST = BW'(DATA_WIDTH - 1);

`ifdef UART_TX_STOP2_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    STOP2  = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;
`endif

  state_t          state_reg;
  logic [BW-1:0]   bcnt_reg;
  logic            par_bit_reg;
  logic            par_en_reg;
  logic            sync_err_reg;
  logic            bcnt_last;

  assign bcnt_last = (bcnt_reg == BCNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      bcnt_reg     <= '0;
      par_bit_reg  <= 1'b0;
      par_en_reg   <= 1'b0;
      sync_err_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          bcnt_reg <= '0;
          if (data_valid) begin
            state_reg   <= START;
            // Parity type is folded into the captured bit, so later PAR_TYP changes cannot leak in.
            par_bit_reg <= (^P_DATA) ^ PAR_TYP;
            par_en_reg  <= PAR_EN;
          end
        end
        START: begin
          state_reg <= DATA;
        end
        DATA: begin
          // Serializer done must coincide exactly with the last counted bit.
          if (ser_done != bcnt_last) begin
            sync_err_reg <= 1'b1;
          end
          if (bcnt_last) begin
            bcnt_reg  <= '0;
            state_reg <= par_en_reg ? PARITY : STOP;
          end else begin
            bcnt_reg <= bcnt_reg + 1'b1;
          end
        end
        PARITY: begin
          state_reg <= STOP;
        end
`ifdef UART_TX_STOP2_EN
        STOP: begin
          state_reg <= STOP2;
        end
        STOP2: begin
          state_reg <= IDLE;
        end
`else
        STOP: begin
          state_reg <= IDLE;
        end
`endif
        default: begin
          state_reg <= IDLE;
          bcnt_reg  <= '0;
        end
      endcase
    end
  end

  assign busy     = (state_reg != IDLE);
  assign ser_en   = (state_reg == DATA);
  assign sync_err = sync_err_reg;
`ifdef UART_TX_STOP2_EN
  assign tx_done  = (state_reg == STOP2);
`else
  assign tx_done  = (state_reg == STOP);
`endif

  always_comb begin
    TX_OUT = 1'b1;
    case (state_reg)
      START:   TX_OUT = 1'b0;
      DATA:    TX_OUT = ser_data;
      PARITY:  TX_OUT = par_bit_reg;
      default: TX_OUT = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fsm.sv
// Directed bench for uart_tx_fsm with a behavioural serializer and a per-cycle scoreboard
// of {TX_OUT, busy, ser_en, tx_done, sync_err}.
module tb_uart_tx_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] P_DATA = 8'h00;
  logic       data_valid = 1'b0;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic       ser_done;
  logic       ser_data;
  logic       ser_en;
  logic       busy;
  logic       TX_OUT;
  logic       tx_done;
  logic       sync_err;

  always #5 clk = ~clk;

  uart_tx_fsm #(.DATA_WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .P_DATA     (P_DATA),
    .data_valid (data_valid),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .ser_done   (ser_done),
    .ser_data   (ser_data),
    .ser_en     (ser_en),
    .busy       (busy),
    .TX_OUT     (TX_OUT),
    .tx_done    (tx_done),
    .sync_err   (sync_err)
  );

  // Behavioural 8-bit LSB-first serializer, loaded when the bench knows a byte is accepted.
  logic [7:0] sh_reg = 8'h00;
  logic [2:0] scnt_reg = 3'd0;
  logic       ser_load = 1'b0;
  logic       force_done = 1'b0;

  always @(posedge clk) begin
    if (ser_load) begin
      sh_reg   <= P_DATA;
      scnt_reg <= 3'd0;
    end else if (ser_en) begin
      sh_reg   <= sh_reg >> 1;
      scnt_reg <= scnt_reg + 3'd1;
    end
  end

  assign ser_data = sh_reg[0];
  assign ser_done = (ser_en && (scnt_reg == 3'd7)) || force_done;

  logic [4:0] exp_q[$];
  string      tag_q[$];
  int         n_cmp = 0;
  int         n_err = 0;
  logic       exp_serr = 1'b0;

  task automatic push(input logic [4:0] v, input string t);
    exp_q.push_back(v);
    tag_q.push_back(t);
  endtask

  task automatic check_one();
    logic [4:0] e;
    logic [4:0] o;
    string      t;
    o = {TX_OUT, busy, ser_en, tx_done, sync_err};
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++;
      $error("FAIL sb_empty: observed=%b expected=<entry>", o);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (o === e) else begin
        n_err++;
        $error("FAIL %s: observed=%b expected=%b (tx,busy,en,done,serr)", t, o, e);
      end
    end
  endtask

  // Called at a negedge while the DUT is idle; returns at the negedge of the idle cycle after the frame.
  task automatic send_frame(input logic [7:0] d, input logic pen, input logic ptyp,
                            input bit hold, input int toggle_at, input int force_at,
                            input int abort_at, input string name);
    logic s;
    int   k;
    P_DATA     = d;
    PAR_EN     = pen;
    PAR_TYP    = ptyp;
    data_valid = 1'b1;
    ser_load   = 1'b1;
    push({1'b0, 1'b1, 1'b0, 1'b0, exp_serr}, {name, "_start"});
    for (int i = 0; i < 8; i++) begin
      if (abort_at < 0 || i <= abort_at) begin
        s = exp_serr | ((force_at >= 0) && (i >= force_at + 1));
        push({d[i], 1'b1, 1'b1, 1'b0, s}, $sformatf("%s_d%0d", name, i));
      end
    end
    if (abort_at < 0) begin
      s = exp_serr | (force_at >= 0);
      if (pen) push({(^d) ^ ptyp, 1'b1, 1'b0, 1'b0, s}, {name, "_parity"});
`ifdef UART_TX_STOP2_EN
      push({1'b1, 1'b1, 1'b0, 1'b0, s}, {name, "_stop"});
      push({1'b1, 1'b1, 1'b0, 1'b1, s}, {name, "_stop2"});
`else
      push({1'b1, 1'b1, 1'b0, 1'b1, s}, {name, "_stop"});
`endif
      push({1'b1, 1'b0, 1'b0, 1'b0, s}, {name, "_idle"});
      exp_serr = s;
    end else begin
      push({1'b1, 1'b0, 1'b0, 1'b0, 1'b0}, {name, "_after_rst"});
      exp_serr = 1'b0;
    end
    k = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      if (k == 0) begin
        data_valid = hold;
        ser_load   = 1'b0;
      end
      check_one();
      if (k == toggle_at) PAR_EN = ~pen;
      force_done = (force_at >= 0) && (k == force_at + 1);
      rst        = (abort_at >= 0) && (k == abort_at + 1);
      k++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held for two cycles, then idle after release.
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      push(5'b1_0_0_0_0, "rst_hold");
      check_one();
    end
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      push(5'b1_0_0_0_0, "rst_idle");
      check_one();
    end

    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, -1, -1, -1, "a5_nopar");
    send_frame(8'h07, 1'b1, 1'b0, 1'b0, -1, -1, -1, "07_even");
    send_frame(8'h07, 1'b1, 1'b1, 1'b0, -1, -1, -1, "07_odd");

    // data_valid held across both frames; PAR_EN flips mid-frame on the first.
    send_frame(8'h55, 1'b1, 1'b0, 1'b1, 3, -1, -1, "55_hold");
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, -1, -1, -1, "3c_next");

    send_frame(8'hC3, 1'b1, 1'b1, 1'b0, -1, -1, 3, "c3_abort");
    send_frame(8'h81, 1'b0, 1'b0, 1'b0, -1, -1, -1, "81_clean");

    send_frame(8'h96, 1'b1, 1'b0, 1'b0, -1, 3, -1, "96_serr");
    send_frame(8'h12, 1'b0, 1'b1, 1'b0, -1, -1, -1, "12_sticky");

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_serr = 1'b0;
    push(5'b1_0_0_0_0, "serr_clear");
    check_one();
    @(negedge clk);
    push(5'b1_0_0_0_0, "serr_idle");
    check_one();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
